// File: rtl/alu_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_if
// Purpose : bundles every handshake/bus signal of the shared-ALU arbiter:
//           two request ports, the response port, the ALU-facing bus and
//           the busy status flag.
// Ports (signals):
//   req0_valid/req0_ready/req0_ctrl/req0_a/req0_b : requester 0 channel
//   req1_valid/req1_ready/req1_ctrl/req1_a/req1_b : requester 1 channel
//   rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_zero/rsp_err : response channel
//   alu_ctrl/alu_a/alu_b                           : arbiter -> ALU operands
//   alu_result/alu_zero                            : ALU -> arbiter results
//   busy                                           : arbiter not idle
// Modports:
//   slave  : the arbiter side
//   master : the surrounding logic (requesters, consumer and the ALU)
// ---------------------------------------------------------------------------
interface alu_share_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [CTRL_W-1:0] req0_ctrl;
  logic [WIDTH-1:0]  req0_a;
  logic [WIDTH-1:0]  req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic [CTRL_W-1:0] req1_ctrl;
  logic [WIDTH-1:0]  req1_a;
  logic [WIDTH-1:0]  req1_b;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [WIDTH-1:0]  rsp_result;
  logic              rsp_zero;
  logic              rsp_err;

  logic [CTRL_W-1:0] alu_ctrl;
  logic [WIDTH-1:0]  alu_a;
  logic [WIDTH-1:0]  alu_b;
  logic [WIDTH-1:0]  alu_result;
  logic              alu_zero;

  logic              busy;

  modport slave (
    input  req0_valid, req0_ctrl, req0_a, req0_b,
    input  req1_valid, req1_ctrl, req1_a, req1_b,
    input  rsp_ready, alu_result, alu_zero,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
    output alu_ctrl, alu_a, alu_b, busy
  );

  modport master (
    output req0_valid, req0_ctrl, req0_a, req0_b,
    output req1_valid, req1_ctrl, req1_a, req1_b,
    output rsp_ready, alu_result, alu_zero,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
    input  alu_ctrl, alu_a, alu_b, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Purpose : shares one combinational ALU between two requesters. A request
//           is accepted in IDLE (round-robin between the ports), its
//           operands are latched and drive the ALU during EXEC, the result
//           and Zero flag are registered and presented on the response
//           channel (RESP) until the consumer takes them.
// Ports   :
//   Clk   in  clock, all state on the rising edge
//   Reset in  synchronous active-high reset
//   bus   alu_share_arbiter_if.slave : request/response/ALU bus and busy
// Parameters:
//   WIDTH      operand/result width
//   CTRL_W     ALU control width
//   MUL_CYCLES EXEC length for multiply (2..15), only with the macro below
// Configuration macro:
//   ALU_ARB_MUL_STALL_EN  when defined, multiply (code 4'b0010) holds EXEC
//                         for MUL_CYCLES cycles; otherwise every code takes
//                         a single EXEC cycle.
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int WIDTH      = 32,
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  alu_share_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q;
  logic              lastGrant_q;
  logic              id_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  result_q;
  logic              zero_q;
  logic              err_q;
  logic              rspValid_q;
`ifdef ALU_ARB_MUL_STALL_EN
  logic [3:0]        mulCnt_q;
`endif

  logic              grantPort;
  logic              idleOpen;
  logic              ready0;
  logic              ready1;
  logic              accept;
  logic [CTRL_W-1:0] selCtrl;
  logic [WIDTH-1:0]  selA;
  logic [WIDTH-1:0]  selB;
  logic              selIllegal;

  // Grant selection: a lone valid port wins outright; on a tie (or when
  // nobody is asking) the port that was not served last gets the grant.
  // Ready is offered only to the granted port and never during Reset.
  always_comb begin
    grantPort = ~lastGrant_q;
    if (bus.req0_valid && !bus.req1_valid) begin
      grantPort = 1'b0;
    end else if (bus.req1_valid && !bus.req0_valid) begin
      grantPort = 1'b1;
    end
    idleOpen   = (state_q == IDLE) && !Reset;
    ready0     = idleOpen && !grantPort;
    ready1     = idleOpen && grantPort;
    accept     = (ready0 && bus.req0_valid) || (ready1 && bus.req1_valid);
    selCtrl    = grantPort ? bus.req1_ctrl : bus.req0_ctrl;
    selA       = grantPort ? bus.req1_a    : bus.req0_a;
    selB       = grantPort ? bus.req1_b    : bus.req0_b;
    // Codes C..E have no ALU meaning and are answered without an EXEC pass.
    selIllegal = (selCtrl == CTRL_W'(4'hC)) || (selCtrl == CTRL_W'(4'hD)) ||
                 (selCtrl == CTRL_W'(4'hE));
  end

  // Main control FSM. The operand registers double as the ALU drive
  // registers, so the ALU inputs keep their last values outside EXEC.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      id_q        <= 1'b0;
      ctrl_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      rspValid_q  <= 1'b0;
`ifdef ALU_ARB_MUL_STALL_EN
      mulCnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            id_q        <= grantPort;
            lastGrant_q <= grantPort;
            ctrl_q      <= selCtrl;
            a_q         <= selA;
            b_q         <= selB;
`ifdef ALU_ARB_MUL_STALL_EN
            // Multiply stays MUL_CYCLES cycles in EXEC; counter hits 0 on
            // the final one.
            mulCnt_q    <= (selCtrl == CTRL_W'(4'h2)) ? 4'(MUL_CYCLES - 1) : 4'd0;
`endif
            if (selIllegal) begin
              result_q   <= '0;
              zero_q     <= 1'b1;
              err_q      <= 1'b1;
              rspValid_q <= 1'b1;
              state_q    <= RESP;
            end else begin
              state_q    <= EXEC;
            end
          end
        end
        EXEC: begin
`ifdef ALU_ARB_MUL_STALL_EN
          if (mulCnt_q != 4'd0) begin
            mulCnt_q <= mulCnt_q - 4'd1;
          end else begin
            result_q   <= bus.alu_result;
            zero_q     <= bus.alu_zero;
            err_q      <= 1'b0;
            rspValid_q <= 1'b1;
            state_q    <= RESP;
          end
`else
          result_q   <= bus.alu_result;
          zero_q     <= bus.alu_zero;
          err_q      <= 1'b0;
          rspValid_q <= 1'b1;
          state_q    <= RESP;
`endif
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rspValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_valid  = rspValid_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.rsp_err    = err_q;
  assign bus.alu_ctrl   = ctrl_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.busy       = (state_q != IDLE);

endmodule
